// File: rtl/fpcvt_seq_ctrl_if.sv
// Handshake/result bundle for fpcvt_seq_ctrl.
// The master side is the sample source plus the result consumer.
// The slave side is the converter itself.
interface fpcvt_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_d;
    logic        out_valid;
    logic        out_ready;
    logic        out_s;
    logic [2:0]  out_e;
    logic [3:0]  out_f;
    logic        busy;

    modport master (
        output in_valid,
        output in_d,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_s,
        input  out_e,
        input  out_f,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_d,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_s,
        output out_e,
        output out_f,
        output busy
    );
endinterface

// File: rtl/fpcvt_seq_ctrl.sv
// fpcvt_seq_ctrl: sequential 12-bit two's-complement to 8-bit float converter.
// The result format is S, E[2:0], F[3:0], and its value is F * 2^E.
// Each accepted sample goes through normalise, then round, then present,
// with a valid/ready handshake on both sides.
// Optional macro FPCVT_FAST_NORM_EN: normalises in a single cycle with a
// priority encoder. When the macro is undefined, normalisation shifts left
// by one bit per cycle.
// HOLD_LAST=1 keeps the last result on out_s/out_e/out_f after the output
// handshake. HOLD_LAST=0 clears them when the block returns to IDLE.
module fpcvt_seq_ctrl #(
    parameter bit HOLD_LAST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    fpcvt_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        s_q, s_d;
    logic        sat_q, sat_d;
    logic [11:0] w_q, w_d;
    logic [2:0]  e_q, e_d;
    logic        out_s_q, out_s_d;
    logic [2:0]  out_e_q, out_e_d;
    logic [3:0]  out_f_q, out_f_d;

    logic [11:0] mag;
    logic [3:0]  f0;
    logic        rnd;

`ifdef FPCVT_FAST_NORM_EN
    // Shift that moves the leading one of m up to bit 10, capped at 7.
    // Bit 11 is only set for -2048, and that value never reaches NORM.
    function automatic logic [2:0] norm_shift(input logic [11:0] m);
        logic [2:0] k;
        k = 3'd7;
        for (int unsigned i = 4; i <= 10; i++) begin
            if (m[i]) begin
                k = 3'(10 - i);
            end
        end
        return k;
    endfunction

    logic [2:0] k_fast;
    assign k_fast = norm_shift(w_q);
`endif

    // Magnitude of the incoming sample.
    // -2048 wraps back to 12'h800, and that value is handled by the sat path.
    always_comb begin
        mag = bus.in_d[11] ? (~bus.in_d + 12'd1) : bus.in_d;
    end

    assign f0  = w_q[10:7];
    assign rnd = w_q[6];

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_s     = out_s_q;
    assign bus.out_e     = out_e_q;
    assign bus.out_f     = out_f_q;

    // Next-state and datapath updates for capture, normalise, round and present.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        sat_d   = sat_q;
        w_d     = w_q;
        e_d     = e_q;
        out_s_d = out_s_q;
        out_e_d = out_e_q;
        out_f_d = out_f_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    s_d = bus.in_d[11];
                    w_d = mag;
                    e_d = 3'd7;
                    if (bus.in_d == 12'h800) begin
                        sat_d   = 1'b1;
                        state_d = ROUND;
                    end else begin
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
`ifdef FPCVT_FAST_NORM_EN
                // Gives the same w/e as the iterative loop, but in one step.
                w_d     = w_q << k_fast;
                e_d     = 3'd7 - k_fast;
                state_d = ROUND;
`else
                if (w_q[10] || (e_q == 3'd0)) begin
                    state_d = ROUND;
                end else begin
                    w_d = w_q << 1;
                    e_d = e_q - 3'd1;
                end
`endif
            end

            ROUND: begin
                out_s_d = s_q;
                if (sat_q) begin
                    out_e_d = 3'd7;
                    out_f_d = 4'hF;
                end else if (!rnd) begin
                    out_e_d = e_q;
                    out_f_d = f0;
                end else if (f0 != 4'hF) begin
                    out_e_d = e_q;
                    out_f_d = f0 + 4'd1;
                end else if (e_q != 3'd7) begin
                    // A carry out of the significand renormalises to 1000.
                    out_e_d = e_q + 3'd1;
                    out_f_d = 4'b1000;
                end else begin
                    out_e_d = 3'd7;
                    out_f_d = 4'hF;
                end
                state_d = DONE;
            end

            DONE: begin
                if (bus.out_ready) begin
                    sat_d   = 1'b0;
                    state_d = IDLE;
                    if (!HOLD_LAST) begin
                        out_s_d = 1'b0;
                        out_e_d = '0;
                        out_f_d = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    // An asynchronous reset discards any transaction that is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            sat_q   <= 1'b0;
            w_q     <= '0;
            e_q     <= '0;
            out_s_q <= 1'b0;
            out_e_q <= '0;
            out_f_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            sat_q   <= sat_d;
            w_q     <= w_d;
            e_q     <= e_d;
            out_s_q <= out_s_d;
            out_e_q <= out_e_d;
            out_f_q <= out_f_d;
        end
    end

endmodule
